interconnect_link_splitter: RTL and testbench



---
 rtl/interconnect_link_splitter_if.sv | 34 +++
 rtl/interconnect_link_splitter.sv | 138 +++++++++++++
 tb/tb_interconnect_link_splitter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/interconnect_link_splitter_if.sv
// Shared interconnect widths and packet type, plus the local link and the
// multi-plane interconnect bundle used by interconnect_link_splitter.
package interconnect_pkg;
    parameter int TIA_NUM_PHYSICAL_PLANES = 3;
    parameter int TIA_TAG_WIDTH           = 4;
    parameter int TIA_WORD_WIDTH          = 8;
    parameter int TIA_PLANE_W = (TIA_NUM_PHYSICAL_PLANES > 1) ? $clog2(TIA_NUM_PHYSICAL_PLANES) : 1;

    typedef struct packed {
        logic [TIA_TAG_WIDTH-1:0]  tag;
        logic [TIA_WORD_WIDTH-1:0] data;
    } packet_t;
endpackage

interface link_if;
    import interconnect_pkg::*;
    logic    req;
    logic    ack;
    packet_t packet;

    modport sender   (output req, output packet, input  ack);
    modport receiver (input  req, input  packet, output ack);
endinterface

interface interconnect_link_if;
    import interconnect_pkg::*;
    logic [TIA_NUM_PHYSICAL_PLANES-1:0]                     reqs;
    logic [TIA_NUM_PHYSICAL_PLANES-1:0]                     acks;
    logic [TIA_NUM_PHYSICAL_PLANES-1:0][TIA_TAG_WIDTH-1:0]  tag_lines;
    logic [TIA_NUM_PHYSICAL_PLANES-1:0][TIA_WORD_WIDTH-1:0] data_lines;

    modport sender   (output reqs, output tag_lines, output data_lines, input  acks);
    modport receiver (input  reqs, input  tag_lines, input  data_lines, output acks);
endinterface

// File: rtl/interconnect_link_splitter.sv
// Buffers packets from one local link and forwards them on a selectable
// physical plane; plane changes drain the FIFO first to keep ordering.
module interconnect_link_splitter
    import interconnect_pkg::*;
#(
    parameter int BUFFER_DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    link_if.receiver                     input_link,
    interconnect_link_if.sender          output_interconnect_link,
    input  logic                         plane_select_write,
    input  logic [TIA_PLANE_W-1:0]       plane_select_value,
    output logic [TIA_PLANE_W-1:0]       current_plane,
    output logic                         busy,
    output logic [$clog2(BUFFER_DEPTH):0] occupancy,
    output logic                         plane_select_error
);
    localparam int NP = TIA_NUM_PHYSICAL_PLANES;
    localparam int PW = TIA_PLANE_W;
    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(BUFFER_DEPTH);
    localparam logic [PW:0] NP_W    = (PW+1)'(NP);

    typedef enum logic {ST_ACTIVE, ST_DRAIN} state_t;

    state_t        r_state;
    logic [PW-1:0] r_cur;
    logic [PW-1:0] r_pending;
    logic          r_err;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    packet_t       r_mem [BUFFER_DEPTH];

    logic          w_sel_valid;
    logic          w_sel_ok;
    logic          w_nonempty;
    logic          w_push;
    logic          w_pop;
    logic          w_in_ack;
    logic [NP-1:0] w_sel;
    logic [NP-1:0] w_reqs;
    logic [NP-1:0][TIA_TAG_WIDTH-1:0]  w_tags;
    logic [NP-1:0][TIA_WORD_WIDTH-1:0] w_data;
    packet_t       w_head;

    assign w_sel_valid = ({1'b0, plane_select_value} < NP_W);
    assign w_sel_ok    = plane_select_write && w_sel_valid;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_nonempty  = (r_count != '0) && !reset;

    // Input ack looks only at local state so it never waits on a plane ack.
    assign w_in_ack = (r_state == ST_ACTIVE) && (r_count < DEPTH_W) && !reset;
    assign w_push   = input_link.req && w_in_ack;
    assign w_pop    = |(w_reqs & output_interconnect_link.acks);

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            w_sel[p]  = (r_cur == PW'(p));
            w_reqs[p] = 1'b0;
            w_tags[p] = '0;
            w_data[p] = '0;
            if (w_sel[p]) begin
                w_reqs[p] = w_nonempty;
                w_tags[p] = w_head.tag;
                w_data[p] = w_head.data;
            end
        end
    end

    assign input_link.ack                      = w_in_ack;
    assign output_interconnect_link.reqs       = w_reqs;
    assign output_interconnect_link.tag_lines  = w_tags;
    assign output_interconnect_link.data_lines = w_data;
    assign current_plane      = r_cur;
    assign busy               = (r_state == ST_DRAIN);
    assign occupancy          = r_count;
    assign plane_select_error = r_err;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= input_link.packet;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A write landing on the drain-completing edge takes effect immediately.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_ACTIVE;
            r_cur     <= '0;
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            if (plane_select_write && !w_sel_valid) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_ACTIVE: begin
                    if (w_sel_ok) begin
                        r_pending <= plane_select_value;
                        r_state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_sel_ok) begin
                        r_pending <= plane_select_value;
                    end
                    if (r_count == '0) begin
                        r_cur   <= w_sel_ok ? plane_select_value : r_pending;
                        r_state <= ST_ACTIVE;
                    end
                end
                default: r_state <= ST_ACTIVE;
            endcase
        end
    end
endmodule

// File: tb/tb_interconnect_link_splitter.sv
// Randomized bench for interconnect_link_splitter against a queue-based model.
module tb_interconnect_link_splitter;
    import interconnect_pkg::*;
    localparam int NP    = TIA_NUM_PHYSICAL_PLANES;
    localparam int PW    = TIA_PLANE_W;
    localparam int DEPTH = 2;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          psw;
    logic [PW-1:0] psv;
    logic [PW-1:0] cur;
    logic          busy;
    logic [OW-1:0] occ;
    logic          perr;

    link_if              lnk ();
    interconnect_link_if ic ();

    interconnect_link_splitter #(.BUFFER_DEPTH(DEPTH)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .input_link               (lnk),
        .output_interconnect_link (ic),
        .plane_select_write       (psw),
        .plane_select_value       (psv),
        .current_plane            (cur),
        .busy                     (busy),
        .occupancy                (occ),
        .plane_select_error       (perr)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    packet_t mq[$];
    int      m_cur, m_pend;
    bit      m_drain, m_err;
    int      pushed, popped;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_cur = 0; m_pend = 0; m_drain = 0; m_err = 0;
    endtask

    task automatic set_in(input bit req, input bit [NP-1:0] acks, input bit sw, input int sv);
        lnk.req        = req;
        lnk.packet.tag = TIA_TAG_WIDTH'($urandom);
        lnk.packet.data= TIA_WORD_WIDTH'($urandom);
        ic.acks        = acks;
        psw            = sw;
        psv            = PW'(sv);
    endtask

    task automatic tick();
        bit [NP-1:0] e_reqs;
        bit          e_ack, push, pop, sel_ok, was_empty;
        @(negedge clock);
        e_ack  = !reset && !m_drain && (mq.size() < DEPTH);
        e_reqs = '0;
        if (!reset && mq.size() > 0) e_reqs[m_cur] = 1'b1;
        check("in_ack", 32'(lnk.ack), 32'(e_ack));
        check("reqs", 32'(ic.reqs), 32'(e_reqs));
        for (int p = 0; p < NP; p++) begin
            if (p != m_cur) begin
                check("idle_tag", 32'(ic.tag_lines[p]), 0);
                check("idle_data", 32'(ic.data_lines[p]), 0);
            end else if (mq.size() > 0) begin
                check("head_tag", 32'(ic.tag_lines[p]), 32'(mq[0].tag));
                check("head_data", 32'(ic.data_lines[p]), 32'(mq[0].data));
            end
        end
        check("cur_plane", 32'(cur), 32'(m_cur));
        check("busy", 32'(busy), 32'(m_drain));
        check("occupancy", 32'(occ), 32'(mq.size()));
        check("sel_err", 32'(perr), 32'(m_err));

        if (reset) begin
            model_clear();
        end else begin
            push      = lnk.req && e_ack;
            pop       = (mq.size() > 0) && ic.acks[m_cur];
            sel_ok    = psw && (int'(psv) < NP);
            was_empty = (mq.size() == 0);
            if (psw && !sel_ok) m_err = 1;
            if (!m_drain) begin
                if (sel_ok) begin m_pend = int'(psv); m_drain = 1; end
            end else begin
                if (sel_ok) m_pend = int'(psv);
                if (was_empty) begin m_cur = m_pend; m_drain = 0; end
            end
            if (pop) begin void'(mq.pop_front()); popped++; end
            if (push) begin mq.push_back(lnk.packet); pushed++; end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int cyc;
        int rand_pushed;
        reset = 1'b1;
        set_in(0, '0, 0, 0);
        @(posedge clock);
        #1;
        model_clear();
        pushed = 0; popped = 0;
        set_in(1, '1, 0, 0);
        tick();
        tick();
        reset = 1'b0;

        // single packet on plane 0
        set_in(1, '1, 0, 0);
        lnk.packet = '{tag: 4'h1, data: 8'hA5};
        tick();
        set_in(0, '1, 0, 0);
        check("first_req0", 32'(ic.reqs), 32'h1);
        check("first_data", 32'(ic.data_lines[0]), 32'hA5);
        tick();
        tick();

        // fill with acks held low, then release
        for (int i = 0; i < 3; i++) begin set_in(1, '0, 0, 0); tick(); end
        check("full_occ", 32'(occ), 2);
        check("full_ack", 32'(lnk.ack), 0);
        for (int i = 0; i < 3; i++) begin set_in(0, '1, 0, 0); tick(); end

        // plane change with two packets buffered
        for (int i = 0; i < 2; i++) begin set_in(1, '0, 0, 0); tick(); end
        set_in(0, '0, 1, 1); tick();
        for (int i = 0; i < 4; i++) begin set_in(1, 3'b010, 0, 0); tick(); end
        set_in(1, 3'b001, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin set_in(1, 3'b011, 0, 0); tick(); end
        check("moved_cur", 32'(cur), 1);

        // empty-FIFO plane change and overwrite during drain
        for (int i = 0; i < 3; i++) begin set_in(0, '1, 0, 0); tick(); end
        set_in(0, '1, 1, 0); tick();
        check("drain_busy", 32'(busy), 1);
        set_in(0, '1, 0, 0); tick();
        check("drain_done", 32'(busy), 0);
        check("drain_cur", 32'(cur), 0);
        set_in(0, '1, 1, 1); tick();
        set_in(0, '1, 1, 2); tick();
        check("overwrite_cur", 32'(cur), 2);

        // out-of-range select is sticky until reset
        set_in(0, '1, 1, NP); tick();
        check("bad_sel_err", 32'(perr), 1);
        check("bad_sel_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin set_in(1, '1, 0, 0); tick(); end
        check("sticky_err", 32'(perr), 1);
        reset = 1'b1; set_in(1, '1, 0, 0); tick();
        reset = 1'b0;

        // randomized traffic with occasional plane changes and resets
        rand_pushed = pushed;
        cyc = 0;
        while ((pushed - rand_pushed) < 1000 && cyc < 20000) begin
            reset = ($urandom_range(0, 399) == 0);
            set_in($urandom_range(0, 3) != 0, NP'($urandom), $urandom_range(0, 29) == 0,
                   $urandom_range(0, NP));
            tick();
            cyc++;
        end
        reset = 1'b0;
        check("rand_pkts", 32'((pushed - rand_pushed) >= 1000), 1);
        for (int i = 0; i < 6; i++) begin set_in(0, '1, 0, 0); tick(); end
        check("final_occ", 32'(occ), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
